// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings and constants for the 5-stage pipeline controller.
// State codes are visible on the state output, so their values are fixed.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Bubbles needed when the register file does write-through; a register
  // file without write-through needs one more.
  localparam logic [1:0] EX_BASE  = 2'd2;
  localparam logic [1:0] MEM_BASE = 2'd1;
  localparam logic [1:0] WB_BASE  = 2'd0;

endpackage

// File: rtl/raw_hazard_detect.sv
// RAW interlock: bubbles ID must wait for its youngest in-flight producer.
// Purely combinational; the datapath has no forwarding paths.
module raw_hazard_detect
  import pipeline_ctrl_pkg::*;
#(
  parameter int RF_WRITE_THROUGH = 1
) (
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic [4:0] ex_dest,
  input  logic       ex_reg_write,
  input  logic [4:0] mem_dest,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_dest,
  input  logic       wb_reg_write,
  output logic [1:0] bubbles
);

  localparam logic [1:0] EXTRA = (RF_WRITE_THROUGH != 0) ? 2'd0 : 2'd1;

  // $zero never carries a dependency, so a zero destination cannot match.
  function automatic logic depends_on(input logic [4:0] dest, input logic wr,
                                      input logic [4:0] rs, input logic [4:0] rt,
                                      input logic uses_rt);
    return wr && (dest != REG_ZERO) && ((dest == rs) || (uses_rt && (dest == rt)));
  endfunction

  logic ex_hit, mem_hit, wb_hit;

  assign ex_hit  = depends_on(ex_dest,  ex_reg_write,  id_rs, id_rt, id_uses_rt);
  assign mem_hit = depends_on(mem_dest, mem_reg_write, id_rs, id_rt, id_uses_rt);
  assign wb_hit  = depends_on(wb_dest,  wb_reg_write,  id_rs, id_rt, id_uses_rt);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    bubbles = 2'd0;
    if (ex_hit)       bubbles = EX_BASE  + EXTRA;
    else if (mem_hit) bubbles = MEM_BASE + EXTRA;
    else if (wb_hit)  bubbles = WB_BASE  + EXTRA;
  end

endmodule

// File: rtl/pipeline_hazard_sequencer.sv
// Pipeline controller: RAW stall interlock, taken-branch squash,
// drain-and-halt sequencing, writeback warm-up gate and saturating statistics.
module pipeline_hazard_sequencer
  import pipeline_ctrl_pkg::*;
#(
  parameter int FILL_CYCLES      = 4,
  parameter int RF_WRITE_THROUGH = 1,
  parameter int DRAIN_CYCLES     = 4,
  parameter int CNT_W            = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_dest,
  input  logic             ex_reg_write,
  input  logic [4:0]       mem_dest,
  input  logic             mem_reg_write,
  input  logic [4:0]       wb_dest,
  input  logic             wb_reg_write,
  input  logic             mem_branch_taken,
  input  logic             halt_req,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             wb_enable,
  output logic             halted,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int FILL_W  = (FILL_CYCLES  > 0) ? $clog2(FILL_CYCLES + 1) : 1;
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES)    : 1;
  localparam logic [FILL_W-1:0]  FILL_DONE  = FILL_W'(FILL_CYCLES);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  state_e             state_q, state_d;
  logic [1:0]         stall_left_q, stall_left_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [FILL_W-1:0]  fill_q;
  logic [CNT_W-1:0]   cycle_q, stall_q, flush_q;
  logic [1:0]         bubbles;
  logic               hazard_bubble;
  logic               branch_squash;

  raw_hazard_detect #(.RF_WRITE_THROUGH(RF_WRITE_THROUGH)) u_detect (
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rt    (id_uses_rt),
    .ex_dest       (ex_dest),
    .ex_reg_write  (ex_reg_write),
    .mem_dest      (mem_dest),
    .mem_reg_write (mem_reg_write),
    .wb_dest       (wb_dest),
    .wb_reg_write  (wb_reg_write),
    .bubbles       (bubbles)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_d       = state_q;
    stall_left_d  = stall_left_q;
    drain_d       = drain_q;
    pc_write      = 1'b0;
    if_id_write   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    halted        = 1'b0;
    hazard_bubble = 1'b0;
    branch_squash = 1'b0;

    // A taken branch outranks stalls and drains: redirect and squash all younger work.
    if (mem_branch_taken && (state_q != ST_HALT)) begin
      branch_squash = 1'b1;
      pc_write      = 1'b1;
      if_id_write   = 1'b1;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      ex_mem_flush  = 1'b1;
      state_d       = ST_RUN;
      stall_left_d  = 2'd0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (bubbles != 2'd0) begin
            id_ex_flush   = 1'b1;
            hazard_bubble = 1'b1;
            if (bubbles > 2'd1) begin
              stall_left_d = bubbles - 2'd1;
              state_d      = ST_STALL;
            end
          end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            if (halt_req) begin
              state_d = ST_DRAIN;
              drain_d = '0;
            end
          end
        end
        ST_STALL: begin
          id_ex_flush   = 1'b1;
          hazard_bubble = 1'b1;
          stall_left_d  = stall_left_q - 2'd1;
          if (stall_left_q == 2'd1) state_d = ST_RUN;
        end
        ST_DRAIN: begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          if (drain_q == DRAIN_LAST) state_d = ST_HALT;
          else                       drain_d = drain_q + DRAIN_W'(1);
        end
        ST_HALT: begin
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
          halted       = 1'b1;
        end
      endcase
    end

    // Outputs are Mealy, so reset has to override them directly to act asynchronously.
    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      halted       = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RUN;
      stall_left_q <= 2'd0;
      drain_q      <= '0;
      fill_q       <= '0;
      cycle_q      <= '0;
      stall_q      <= '0;
      flush_q      <= '0;
    end else begin
      state_q      <= state_d;
      stall_left_q <= stall_left_d;
      drain_q      <= drain_d;
      if (fill_q != FILL_DONE)  fill_q  <= fill_q + FILL_W'(1);
      if (state_q != ST_HALT)   cycle_q <= sat_inc(cycle_q);
      if (hazard_bubble)        stall_q <= sat_inc(stall_q);
      if (branch_squash)        flush_q <= sat_inc(flush_q);
    end
  end

  assign wb_enable   = (fill_q == FILL_DONE) && !reset && (state_q != ST_HALT);
  assign state       = state_q;
  assign cycle_count = cycle_q;
  assign stall_count = stall_q;
  assign flush_count = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Directed bench: write-through, non-write-through and narrow-counter instances
// share one stimulus stream; each expectation is hand-derived.
module tb_pipeline_hazard_sequencer;

  logic       clk;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_dest, mem_dest, wb_dest;
  logic       id_uses_rt, ex_reg_write, mem_reg_write, wb_reg_write;
  logic       mem_branch_taken, halt_req;

  logic        a_pc, a_ifw, a_iff, a_idf, a_exf, a_wbe, a_hlt;
  logic [1:0]  a_st;
  logic [31:0] a_cyc, a_stl, a_fl;

  logic        b_pc, b_ifw, b_iff, b_idf, b_exf, b_wbe, b_hlt;
  logic [1:0]  b_st;
  logic [31:0] b_cyc, b_stl, b_fl;

  logic        s_pc, s_ifw, s_iff, s_idf, s_exf, s_wbe, s_hlt;
  logic [1:0]  s_st;
  logic [1:0]  s_cyc, s_stl, s_fl;

  int errors = 0;
  int checks = 0;
  int ticks_since_rst = 0;
  int exp_stl_a = 0;
  int exp_stl_b = 0;
  int exp_halt_cyc = 0;

  pipeline_hazard_sequencer #(.RF_WRITE_THROUGH(1)) dut_a (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_dest(ex_dest), .ex_reg_write(ex_reg_write), .mem_dest(mem_dest),
    .mem_reg_write(mem_reg_write), .wb_dest(wb_dest), .wb_reg_write(wb_reg_write),
    .mem_branch_taken(mem_branch_taken), .halt_req(halt_req),
    .pc_write(a_pc), .if_id_write(a_ifw), .if_id_flush(a_iff), .id_ex_flush(a_idf),
    .ex_mem_flush(a_exf), .wb_enable(a_wbe), .halted(a_hlt), .state(a_st),
    .cycle_count(a_cyc), .stall_count(a_stl), .flush_count(a_fl)
  );

  pipeline_hazard_sequencer #(.RF_WRITE_THROUGH(0)) dut_b (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_dest(ex_dest), .ex_reg_write(ex_reg_write), .mem_dest(mem_dest),
    .mem_reg_write(mem_reg_write), .wb_dest(wb_dest), .wb_reg_write(wb_reg_write),
    .mem_branch_taken(mem_branch_taken), .halt_req(halt_req),
    .pc_write(b_pc), .if_id_write(b_ifw), .if_id_flush(b_iff), .id_ex_flush(b_idf),
    .ex_mem_flush(b_exf), .wb_enable(b_wbe), .halted(b_hlt), .state(b_st),
    .cycle_count(b_cyc), .stall_count(b_stl), .flush_count(b_fl)
  );

  pipeline_hazard_sequencer #(.CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_dest(ex_dest), .ex_reg_write(ex_reg_write), .mem_dest(mem_dest),
    .mem_reg_write(mem_reg_write), .wb_dest(wb_dest), .wb_reg_write(wb_reg_write),
    .mem_branch_taken(mem_branch_taken), .halt_req(halt_req),
    .pc_write(s_pc), .if_id_write(s_ifw), .if_id_flush(s_iff), .id_ex_flush(s_idf),
    .ex_mem_flush(s_exf), .wb_enable(s_wbe), .halted(s_hlt), .state(s_st),
    .cycle_count(s_cyc), .stall_count(s_stl), .flush_count(s_fl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; checks happen 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
    ticks_since_rst++;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
    ex_dest = 5'd0; ex_reg_write = 1'b0;
    mem_dest = 5'd0; mem_reg_write = 1'b0;
    wb_dest = 5'd0; wb_reg_write = 1'b0;
    mem_branch_taken = 1'b0; halt_req = 1'b0;
  endtask

  task automatic ex_hazard_rs5();
    clear_inputs();
    id_rs = 5'd5; ex_dest = 5'd5; ex_reg_write = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    settle();
    check("rst_pc_write",     32'(a_pc),  32'd0);
    check("rst_if_id_write",  32'(a_ifw), 32'd0);
    check("rst_if_id_flush",  32'(a_iff), 32'd1);
    check("rst_id_ex_flush",  32'(a_idf), 32'd1);
    check("rst_ex_mem_flush", 32'(a_exf), 32'd1);
    check("rst_wb_enable",    32'(a_wbe), 32'd0);
    check("rst_halted",       32'(a_hlt), 32'd0);
    check("rst_state",        32'(a_st),  32'd0);
    check("rst_cycle_count",  a_cyc,      32'd0);
    tick();
    tick();
    reset = 1'b0;
    ticks_since_rst = 0;

    // Warm-up: wb_enable low for exactly FILL_CYCLES cycles, free-running fetch.
    for (int i = 0; i < 10; i++) begin
      settle();
      check($sformatf("fill_wb_enable_c%0d", i), 32'(a_wbe), (i < 4) ? 32'd0 : 32'd1);
      check($sformatf("fill_pc_write_c%0d", i), 32'(a_pc), 32'd1);
      tick();
    end
    settle();
    check("cycle_count_10", a_cyc, 32'd10);
    check("cycle_count_sat", 32'(s_cyc), 32'd3);
    check("no_stall_yet", a_stl, 32'd0);
    tick();

    // EX producer: 2 bubbles with write-through, 3 without.
    ex_hazard_rs5();
    settle();
    check("ex_c0_pc_a",    32'(a_pc),  32'd0);
    check("ex_c0_idex_a",  32'(a_idf), 32'd1);
    check("ex_c0_ifw_a",   32'(a_ifw), 32'd0);
    check("ex_c0_pc_b",    32'(b_pc),  32'd0);
    tick();
    clear_inputs();
    settle();
    check("ex_c1_state_a", 32'(a_st),  32'd1);
    check("ex_c1_pc_a",    32'(a_pc),  32'd0);
    check("ex_c1_idex_a",  32'(a_idf), 32'd1);
    check("ex_c1_state_b", 32'(b_st),  32'd1);
    tick();
    settle();
    check("ex_c2_state_a", 32'(a_st),  32'd0);
    check("ex_c2_pc_a",    32'(a_pc),  32'd1);
    check("ex_c2_idex_a",  32'(a_idf), 32'd0);
    check("ex_c2_pc_b",    32'(b_pc),  32'd0);
    check("ex_c2_state_b", 32'(b_st),  32'd1);
    tick();
    settle();
    check("ex_c3_state_b", 32'(b_st),  32'd0);
    check("ex_c3_pc_b",    32'(b_pc),  32'd1);
    exp_stl_a += 2;
    exp_stl_b += 3;
    check("ex_stall_count_a", a_stl, 32'(exp_stl_a));
    check("ex_stall_count_b", b_stl, 32'(exp_stl_b));
    tick();

    // $zero is never a dependency.
    clear_inputs();
    id_rs = 5'd3; id_rt = 5'd0; id_uses_rt = 1'b1; ex_dest = 5'd0; ex_reg_write = 1'b1;
    settle();
    check("zero_reg_pc_a", 32'(a_pc), 32'd1);
    check("zero_reg_pc_b", 32'(b_pc), 32'd1);
    tick();

    // rt match ignored when the instruction does not read rt.
    clear_inputs();
    id_rs = 5'd3; id_rt = 5'd7; id_uses_rt = 1'b0; ex_dest = 5'd7; ex_reg_write = 1'b1;
    settle();
    check("rt_unused_pc_a", 32'(a_pc), 32'd1);
    check("rt_unused_pc_b", 32'(b_pc), 32'd1);
    tick();

    // rt match honoured when used: producer in WB -> 0 bubbles (write-through) / 1.
    clear_inputs();
    id_rs = 5'd3; id_rt = 5'd9; id_uses_rt = 1'b1; wb_dest = 5'd9; wb_reg_write = 1'b1;
    settle();
    check("wb_pc_a",   32'(a_pc),  32'd1);
    check("wb_pc_b",   32'(b_pc),  32'd0);
    check("wb_idex_b", 32'(b_idf), 32'd1);
    exp_stl_b += 1;
    tick();
    clear_inputs();
    settle();
    check("wb_after_pc_b",    32'(b_pc), 32'd1);
    check("wb_after_state_b", 32'(b_st), 32'd0);
    tick();

    // MEM producer, with an older WB producer of the same register: youngest wins.
    clear_inputs();
    id_rs = 5'd4; mem_dest = 5'd4; mem_reg_write = 1'b1; wb_dest = 5'd4; wb_reg_write = 1'b1;
    settle();
    check("mem_pc_a",    32'(a_pc), 32'd0);
    check("mem_state_a", 32'(a_st), 32'd0);
    check("mem_pc_b",    32'(b_pc), 32'd0);
    tick();
    clear_inputs();
    settle();
    check("mem_c1_pc_a",    32'(a_pc), 32'd1);
    check("mem_c1_state_b", 32'(b_st), 32'd1);
    check("mem_c1_pc_b",    32'(b_pc), 32'd0);
    tick();
    settle();
    check("mem_c2_state_b", 32'(b_st), 32'd0);
    exp_stl_a += 1;
    exp_stl_b += 2;
    check("mem_stall_count_a", a_stl, 32'(exp_stl_a));
    check("mem_stall_count_b", b_stl, 32'(exp_stl_b));
    tick();

    // Taken branch on the second stall cycle aborts the stall.
    ex_hazard_rs5();
    settle();
    check("br_c0_pc_a", 32'(a_pc), 32'd0);
    tick();
    clear_inputs();
    mem_branch_taken = 1'b1;
    settle();
    check("br_pc_a",    32'(a_pc),  32'd1);
    check("br_ifw_a",   32'(a_ifw), 32'd1);
    check("br_iff_a",   32'(a_iff), 32'd1);
    check("br_idf_a",   32'(a_idf), 32'd1);
    check("br_exf_a",   32'(a_exf), 32'd1);
    check("br_exf_b",   32'(b_exf), 32'd1);
    tick();
    clear_inputs();
    settle();
    exp_stl_a += 1;
    exp_stl_b += 1;
    check("br_after_state_a", 32'(a_st), 32'd0);
    check("br_after_flush_a", a_fl,      32'd1);
    check("br_after_stall_a", a_stl,     32'(exp_stl_a));
    check("br_after_state_b", 32'(b_st), 32'd0);
    check("br_after_stall_b", b_stl,     32'(exp_stl_b));
    tick();

    // Halt on the wrong path: branch in drain cycle 2 returns to RUN.
    clear_inputs();
    halt_req = 1'b1;
    settle();
    check("hd_run_pc_a", 32'(a_pc), 32'd1);
    tick();
    clear_inputs();
    settle();
    check("hd_d1_state_a", 32'(a_st),  32'd2);
    check("hd_d1_pc_a",    32'(a_pc),  32'd0);
    check("hd_d1_iff_a",   32'(a_iff), 32'd1);
    tick();
    mem_branch_taken = 1'b1;
    settle();
    check("hd_d2_pc_a",  32'(a_pc),  32'd1);
    check("hd_d2_exf_a", 32'(a_exf), 32'd1);
    tick();
    clear_inputs();
    settle();
    check("hd_after_state_a",  32'(a_st),  32'd0);
    check("hd_after_halted_a", 32'(a_hlt), 32'd0);
    check("hd_after_flush_a",  a_fl,       32'd2);
    tick();

    // Asynchronous reset while stall_left is 2 (non-write-through instance).
    ex_hazard_rs5();
    settle();
    tick();
    clear_inputs();
    settle();
    check("rs_pre_state_b", 32'(b_st), 32'd1);
    reset = 1'b1;
    settle();
    check("rs_state_b",  32'(b_st),  32'd0);
    check("rs_pc_b",     32'(b_pc),  32'd0);
    check("rs_ifw_b",    32'(b_ifw), 32'd0);
    check("rs_iff_b",    32'(b_iff), 32'd1);
    check("rs_idf_b",    32'(b_idf), 32'd1);
    check("rs_exf_b",    32'(b_exf), 32'd1);
    check("rs_wbe_b",    32'(b_wbe), 32'd0);
    check("rs_stall_b",  b_stl,      32'd0);
    check("rs_flush_b",  b_fl,       32'd0);
    tick();
    reset = 1'b0;
    ticks_since_rst = 0;
    settle();
    check("rs_rel_state_b", 32'(b_st),  32'd0);
    check("rs_rel_pc_b",    32'(b_pc),  32'd1);
    check("rs_rel_idf_b",   32'(b_idf), 32'd0);
    tick();
    settle();
    check("rs_rel1_pc_b",    32'(b_pc), 32'd1);
    check("rs_rel1_stall_b", b_stl,     32'd0);
    tick();

    // Full drain-and-halt; cycle_count must freeze.
    clear_inputs();
    halt_req = 1'b1;
    settle();
    check("h_run_pc_a", 32'(a_pc), 32'd1);
    tick();
    clear_inputs();
    for (int k = 0; k < 4; k++) begin
      settle();
      check($sformatf("h_drain%0d_state_a", k), 32'(a_st), 32'd2);
      check($sformatf("h_drain%0d_pc_a", k), 32'(a_pc), 32'd0);
      tick();
    end
    settle();
    exp_halt_cyc = ticks_since_rst;
    check("h_halted_a", 32'(a_hlt), 32'd1);
    check("h_state_a",  32'(a_st),  32'd3);
    check("h_pc_a",     32'(a_pc),  32'd0);
    check("h_ifw_a",    32'(a_ifw), 32'd0);
    check("h_exf_a",    32'(a_exf), 32'd1);
    check("h_cycle_a",  a_cyc,      32'(exp_halt_cyc));
    tick();
    mem_branch_taken = 1'b1;
    tick();
    clear_inputs();
    tick();
    settle();
    check("h_frozen_cycle_a", a_cyc,      32'(exp_halt_cyc));
    check("h_still_halted_a", 32'(a_hlt), 32'd1);
    check("h_still_state_a",  32'(a_st),  32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench did not complete");
  end

endmodule

// File: doc/pipeline_hazard_sequencer.md
Name: pipeline_hazard_sequencer

Overview:
- Central controller for the 5-stage pipeline: fetch, decode, execute, memory, writeBack.
- Each cycle it decides whether the PC and IF/ID register advance, which pipeline registers are flushed to bubbles, and when register-file writeback is permitted after reset.
- Provides the missing interlock: the datapath has no forwarding, so RAW hazards stall decode until the producer commits. It also squashes wrong-path instructions on a taken branch resolved in MEM.
- Sequences an orderly drain-and-halt, and keeps performance counters.

Parameters:
- FILL_CYCLES, 4: cycles after reset before wb_enable rises (pipeline warm-up).
- RF_WRITE_THROUGH, 1: 1 = register file returns WB data to ID in the same cycle; 0 = one extra bubble needed.
- DRAIN_CYCLES, 4: cycles in DRAIN before HALT.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high.
- id_rs  in  5  rs of the instruction in ID.
- id_rt  in  5  rt of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt (R-type, sw, beq).
- ex_dest  in  5  destination register of the instruction in EX.
- ex_reg_write  in  1  regWrite of the instruction in EX.
- mem_dest  in  5  destination register of the instruction in MEM.
- mem_reg_write  in  1  regWrite of the instruction in MEM.
- wb_dest  in  5  destination register of the instruction in WB.
- wb_reg_write  in  1  regWrite of the instruction in WB.
- mem_branch_taken  in  1  branch resolved taken in MEM (PCSrc).
- halt_req  in  1  fetch has seen the halt encoding.
- pc_write  out  1  PC loads its next value.
- if_id_write  out  1  IF/ID register loads.
- if_id_flush  out  1  IF/ID loads a NOP.
- id_ex_flush  out  1  ID/EX loads a bubble (WB/M/EX control bits cleared).
- ex_mem_flush  out  1  EX/MEM loads a bubble.
- wb_enable  out  1  gates regWrite into the register file.
- halted  out  1  sequencer is in HALT.
- state  out  2  RUN=0, STALL=1, DRAIN=2, HALT=3.
- cycle_count  out  CNT_W  cycles spent outside HALT.
- stall_count  out  CNT_W  bubbles inserted by the interlock.
- flush_count  out  CNT_W  taken-branch squashes.

Behaviour:
- Reset (async, while asserted):
  - state=RUN; fill and stall counters 0; all performance counters 0.
  - pc_write=0, if_id_write=0, all three flushes=1, wb_enable=0, halted=0.
- Control outputs are combinational (Mealy) in state and current inputs. State, counters and statistics are registered.
- Hazard detect (evaluated only in RUN): a source register matches a producer when:
  - the source is id_rs, or id_rt with id_uses_rt=1;
  - the source is nonzero;
  - the producer's *_reg_write=1 and its dest equals the source.
- Required bubbles:
  - EX match: 2 + (1-RF_WRITE_THROUGH).
  - MEM match: 1 + (1-RF_WRITE_THROUGH).
  - WB match: 0 + (1-RF_WRITE_THROUGH).
  - Youngest producer wins (EX > MEM > WB). No match = 0.
- RUN:
  - bubbles=0: pc_write=1, if_id_write=1, no flushes.
  - bubbles>0: pc_write=0, if_id_write=0, id_ex_flush=1. This cycle is bubble 1.
  - If bubbles>1: load stall_left=bubbles-1 and go to STALL.
- STALL:
  - Same outputs as a stalling RUN cycle.
  - Hazard inputs are ignored; stall_left decrements each cycle.
  - When stall_left==1, the next state is RUN.
- Taken branch (mem_branch_taken=1 in RUN or STALL) has highest priority:
  - pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=1, ex_mem_flush=1.
  - Any stall is aborted; next state RUN; flush_count+1; no stall bubble is counted.
- halt_req=1 in RUN with no branch: next state DRAIN. Stall, if any, is taken first; halt_req is sampled only in RUN.
- DRAIN:
  - pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1. Older instructions in EX/MEM/WB retire.
  - After DRAIN_CYCLES cycles, go to HALT.
  - mem_branch_taken=1 during DRAIN: the halt was on the wrong path. Apply full branch squash, return to RUN, flush_count+1.
- HALT:
  - All write enables 0, flushes 1, halted=1.
  - cycle_count frozen. Only reset exits.
- wb_enable:
  - 0 until the fill counter reaches FILL_CYCLES after reset release, then 1 permanently.
  - Suppresses writes of X-valued warm-up garbage.
- Counters:
  - stall_count increments on every cycle id_ex_flush is asserted for a hazard.
  - All counters saturate at 2^CNT_W-1 and never wrap.
- Reset mid-STALL or mid-DRAIN: immediate return to reset values. No residual stall_left.

Decomposition:
- pipeline_ctrl_pkg holds:
  - state encoding constants (RUN/STALL/DRAIN/HALT);
  - REG_ZERO=5'd0;
  - bubble base constants EX_BASE=2, MEM_BASE=1, WB_BASE=0.
- One combinational sub-module, raw_hazard_detect: takes the ID sources and the three producer tuples, returns the 2-bit bubble count.

Test Plan:
- Reset release, no hazards:
  - wb_enable=0 for exactly 4 cycles, then 1.
  - pc_write=1 every cycle; cycle_count=10 after 10 cycles.
- id_rs=5, ex_dest=5, ex_reg_write=1, RF_WRITE_THROUGH=1:
  - pc_write=0 and id_ex_flush=1 for exactly 2 cycles, then RUN; stall_count=2.
  - Same stimulus with RF_WRITE_THROUGH=0: 3 cycles.
- id_rt=0, ex_dest=0, ex_reg_write=1: no stall. Also id_rt=7 match with id_uses_rt=0: no stall.
- EX hazard (2 bubbles); mem_branch_taken=1 on the second stall cycle:
  - That cycle: all three flushes=1, pc_write=1.
  - Next cycle: state=RUN; flush_count=1; stall_count=1.
- halt_req=1 in RUN:
  - 4 DRAIN cycles with pc_write=0, then halted=1 and cycle_count stops.
  - Repeat with mem_branch_taken=1 on drain cycle 2: state returns to RUN, halted stays 0.
- Assert reset during STALL with stall_left=2: all outputs take reset values asynchronously. After release, state=RUN with no leftover bubble.
